// File: rtl/fifo_rd_drain.sv
// Read-side consumer for the fifo1 async FIFO: pops FWFT words into a 2-entry
// skid buffer, presents them on a valid/ready stream, and supports pause and flush.
module fifo_rd_drain #(
    parameter int DATASIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                en,
    input  logic                flush,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CNTW-1:0]     rd_count,
    output logic [CNTW-1:0]     drop_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [DATASIZE-1:0] ent0;
    logic [DATASIZE-1:0] ent1;
    logic                push;
    logic                pop;
    logic                flush_entry;
    logic [1:0]          discard;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                input logic [1:0]      b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {{(CNTW-1){1'b0}}, b};
        return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
    endfunction

    // Fetch uses only registered cnt so m_ready never reaches rinc combinationally.
    always_comb begin
        rinc = 1'b0;
        case (state)
            RUN:     rinc = !rempty && (cnt < 2'd2);
            FLUSH:   rinc = !rempty;
            default: rinc = 1'b0;
        endcase
    end

    assign push        = (state == RUN) && rinc;
    assign m_valid     = (cnt != 2'd0);
    assign pop         = m_valid && m_ready;
    assign m_data      = ent0;
    assign busy        = (state != IDLE) || m_valid;
    assign flush_entry = flush && (state != FLUSH);
    // Words left in the buffer after this edge's traffic are the ones thrown away.
    assign discard     = cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            ent0       <= '0;
            ent1       <= '0;
            rd_count   <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush)   state <= FLUSH;
                    else if (en) state <= RUN;
                end
                RUN: begin
                    if (flush)    state <= FLUSH;
                    else if (!en) state <= IDLE;
                end
                FLUSH: begin
                    if (!flush && rempty) state <= en ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (pop) rd_count <= rd_count + CNTW'(1);

            if (flush_entry) begin
                cnt        <= 2'd0;
                drop_count <= sat_add(drop_count, discard);
            end else if (state == FLUSH) begin
                if (rinc) drop_count <= sat_add(drop_count, 2'd1);
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (cnt == 2'd0) ent0 <= rdata;
                        else             ent1 <= rdata;
                        cnt <= cnt + 2'd1;
                    end
                    2'b01: begin
                        ent0 <= ent1;
                        cnt  <= cnt - 2'd1;
                    end
                    2'b11: begin
                        // push implies cnt<2, so only the single-entry case occurs
                        if (cnt == 2'd1) begin
                            ent0 <= rdata;
                        end else begin
                            ent0 <= ent1;
                            ent1 <= rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: a queue stands in for fifo1; a second
// instance with 4-bit counters shares all inputs to exercise wrap/saturation.
module tb_fifo_rd_drain;

    logic       clk = 1'b0;
    logic       rrst, en, flush, rempty, m_ready;
    logic [7:0] rdata;

    logic        rinc, m_valid, busy;
    logic [7:0]  m_data;
    logic [15:0] rd_count, drop_count;

    logic       rinc4, m_valid4, busy4;
    logic [7:0] m_data4;
    logic [3:0] rd_count4, drop_count4;

    logic [7:0] fq[$];
    logic [7:0] rx[$];
    int         rx_cyc[$];
    logic [7:0] ex[$];
    int         cyc = 0;
    int         pops = 0;
    int         bad_rinc = 0;
    int         inst_diff = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    fifo_rd_drain #(.DATASIZE(8), .CNTW(16)) u_dut (
        .rclk(clk), .rrst(rrst), .en(en), .flush(flush), .rempty(rempty),
        .rdata(rdata), .rinc(rinc), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rd_count(rd_count), .drop_count(drop_count), .busy(busy)
    );

    fifo_rd_drain #(.DATASIZE(8), .CNTW(4)) u_dut4 (
        .rclk(clk), .rrst(rrst), .en(en), .flush(flush), .rempty(rempty),
        .rdata(rdata), .rinc(rinc4), .m_data(m_data4), .m_valid(m_valid4),
        .m_ready(m_ready), .rd_count(rd_count4), .drop_count(drop_count4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // Sample at the falling edge, advance one rising edge, then update the FIFO model.
    task automatic tick();
        logic       r_s;
        logic [7:0] tmp;
        @(negedge clk);
        r_s = rinc;
        if (rinc && rempty) bad_rinc++;
        if (rinc4 !== rinc || m_valid4 !== m_valid || m_data4 !== m_data || busy4 !== busy)
            inst_diff++;
        if (m_valid && m_ready) begin
            rx.push_back(m_data);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r_s) begin
            if (fq.size() != 0) tmp = fq.pop_front();
            pops++;
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        rrst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fq.delete();
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        rrst = 1'b0;
        rx.delete();
        rx_cyc.delete();
        pops = 0;
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(rx.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < rx.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(rx[i]), 32'(ex[i]));
    endtask

    initial begin
        // Reset with a word present in the FIFO
        rrst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fq.delete(); fq.push_back(8'h5A);
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_rdcnt", 32'(rd_count), 32'd0);
        chk("rst_dropcnt", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Stream FF,F1..F7 at full rate
        do_reset();
        ex.delete();
        fq.push_back(8'hFF); ex.push_back(8'hFF);
        for (int i = 1; i <= 7; i++) begin
            fq.push_back(8'hF0 + 8'(i));
            ex.push_back(8'hF0 + 8'(i));
        end
        drive_fifo();
        en = 1'b1; m_ready = 1'b1;
        repeat (14) tick();
        check_stream("stream");
        if (rx_cyc.size() == 8) chk("stream_gap", 32'(rx_cyc[7] - rx_cyc[0]), 32'd7);
        chk("stream_rdcnt", 32'(rd_count), 32'd8);
        chk("stream_pops", 32'(pops), 32'd8);
        chk("stream_rinc_empty", 32'(rinc), 32'd0);

        // Backpressure: 16 words, sink stalled
        do_reset();
        ex.delete();
        fq.push_back(8'hFF); ex.push_back(8'hFF);
        for (int i = 1; i <= 15; i++) begin
            fq.push_back(8'(i));
            ex.push_back(8'(i));
        end
        drive_fifo();
        en = 1'b1;
        repeat (10) tick();
        chk("bp_pops", 32'(pops), 32'd2);
        chk("bp_mvalid", 32'(m_valid), 32'd1);
        chk("bp_mdata", 32'(m_data), 32'hFF);
        chk("bp_rinc", 32'(rinc), 32'd0);
        m_ready = 1'b1;
        repeat (25) tick();
        check_stream("bp");
        chk("bp_rdcnt", 32'(rd_count), 32'd16);

        // Pause with a full buffer
        do_reset();
        ex.delete();
        for (int i = 0; i < 6; i++) begin
            fq.push_back(8'hA0 + 8'(i));
            ex.push_back(8'hA0 + 8'(i));
        end
        drive_fifo();
        en = 1'b1;
        repeat (3) tick();
        chk("pause_fill", 32'(pops), 32'd2);
        en = 1'b0;
        chk("pause_rinc", 32'(rinc), 32'd0);
        repeat (2) tick();
        m_ready = 1'b1;
        repeat (4) tick();
        chk("pause_drained", 32'(rx.size()), 32'd2);
        chk("pause_pops", 32'(pops), 32'd2);
        chk("pause_busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (10) tick();
        check_stream("pause");
        chk("pause_rdcnt", 32'(rd_count), 32'd6);

        // Flush with 2 buffered and 8 still in the FIFO
        do_reset();
        for (int i = 0; i < 10; i++) fq.push_back(8'hB0 + 8'(i));
        drive_fifo();
        en = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        chk("flush_mvalid", 32'(m_valid), 32'd0);
        chk("flush_entry_drop", 32'(drop_count), 32'd2);
        m_ready = 1'b1;
        repeat (12) tick();
        chk("flush_pops", 32'(pops), 32'd10);
        chk("flush_drop", 32'(drop_count), 32'd10);
        chk("flush_drop4", 32'(drop_count4), 32'd10);
        chk("flush_rinc", 32'(rinc), 32'd0);
        flush = 1'b0;
        repeat (2) tick();
        chk("flush_busy_run", 32'(busy), 32'd1);
        fq.push_back(8'hC5);
        drive_fifo();
        repeat (4) tick();
        ex.delete(); ex.push_back(8'hC5);
        check_stream("flush_resume");

        // Second flush from IDLE pushes the 4-bit drop counter into saturation
        en = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) fq.push_back(8'hD0 + 8'(i));
        drive_fifo();
        flush = 1'b1;
        repeat (12) tick();
        flush = 1'b0;
        repeat (2) tick();
        chk("sat_drop16", 32'(drop_count), 32'd18);
        chk("sat_drop4", 32'(drop_count4), 32'd15);
        chk("sat_pops", 32'(pops), 32'd19);
        chk("sat_no_emit", 32'(rx.size()), 32'd1);
        chk("sat_busy_idle", 32'(busy), 32'd0);

        // rd_count wrap with 4-bit counters
        do_reset();
        for (int i = 0; i < 17; i++) fq.push_back(8'h30 + 8'(i));
        drive_fifo();
        en = 1'b1; m_ready = 1'b1;
        repeat (24) tick();
        chk("wrap_rdcnt16", 32'(rd_count), 32'd17);
        chk("wrap_rdcnt4", 32'(rd_count4), 32'd1);
        chk("wrap_len", 32'(rx.size()), 32'd17);
        if (rx.size() == 17) chk("wrap_last", 32'(rx[16]), 32'h40);

        chk("rinc_while_empty", 32'(bad_rinc), 32'd0);
        chk("instance_agree", 32'(inst_diff), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
